// File: rtl/sonata_pkg.sv
// rtl/sonata_pkg.sv - pinmux register-map constants and address decode types
package sonata_pkg;

  localparam int unsigned PINMUX_ADDR_W  = 10;
  localparam int unsigned PINMUX_IDX_W   = 8;
  localparam int unsigned PINMUX_BLANK_W = 8;

  typedef enum logic [1:0] {
    PINMUX_BANK_OUT    = 2'd0,
    PINMUX_BANK_SINK   = 2'd1,
    PINMUX_BANK_STATUS = 2'd2,
    PINMUX_BANK_RSVD   = 2'd3
  } pinmux_bank_e;

  typedef logic [PINMUX_IDX_W-1:0] pinmux_idx_t;

  typedef struct packed {
    pinmux_bank_e bank;
    pinmux_idx_t  idx;
  } pinmux_addr_t;

  function automatic pinmux_addr_t pinmux_decode(input logic [PINMUX_ADDR_W-1:0] addr);
    return pinmux_addr_t'(addr);
  endfunction

endpackage

// File: rtl/sonata_pinmux_out_slot.sv
// rtl/sonata_pinmux_out_slot.sv - one output pin: pending/active select, break-before-make blank, source mux
module sonata_pinmux_out_slot
  import sonata_pkg::*;
#(
  parameter int unsigned NumSrc      = 8,
  parameter int unsigned SelW        = $clog2(NumSrc + 1),
  parameter int unsigned BlankCycles = 4,
  parameter logic [SelW-1:0] SelRst  = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [SelW-1:0]   wr_sel_i,
  input  logic [NumSrc-1:0] src_o_i,
  input  logic [NumSrc-1:0] src_oe_i,
  output logic [SelW-1:0]   pend_sel_o,
  output logic              busy_o,
  output logic              pin_o,
  output logic              pin_oe_o
);

  localparam logic [PINMUX_BLANK_W-1:0] BlankLoad = PINMUX_BLANK_W'(BlankCycles);
  localparam logic [PINMUX_BLANK_W-1:0] BlankOne  = PINMUX_BLANK_W'(1);

  logic [SelW-1:0]           r_pend_sel;
  logic [SelW-1:0]           r_act_sel;
  logic [PINMUX_BLANK_W-1:0] r_blank_cnt;
  logic                      w_change;

  // Rewriting the current pending select must not restart the blank.
  assign w_change = wr_en_i && (wr_sel_i != r_pend_sel);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend_sel  <= SelRst;
      r_act_sel   <= SelRst;
      r_blank_cnt <= '0;
    end else if (w_change) begin
      r_pend_sel <= wr_sel_i;
      if (BlankCycles == 0) begin
        r_act_sel <= wr_sel_i;
      end else begin
        r_act_sel   <= '0;
        r_blank_cnt <= BlankLoad;
      end
    end else if (r_blank_cnt != '0) begin
      r_blank_cnt <= r_blank_cnt - BlankOne;
      if (r_blank_cnt == BlankOne) begin
        r_act_sel <= r_pend_sel;
      end
    end
  end

  always_comb begin
    pin_o    = 1'b0;
    pin_oe_o = 1'b0;
    for (int k = 0; k < NumSrc; k++) begin
      if (r_act_sel == SelW'(k + 1)) begin
        pin_o    = src_o_i[k];
        pin_oe_o = src_oe_i[k];
      end
    end
  end

  assign pend_sel_o = r_pend_sel;
  assign busy_o     = (r_blank_cnt != '0);

endmodule

// File: rtl/sonata_pinmux_ctrl.sv
// rtl/sonata_pinmux_ctrl.sv - programmable pin multiplexer: register port, output slots, input synchronisers, sink muxes
module sonata_pinmux_ctrl
  import sonata_pkg::*;
#(
  parameter int unsigned NumOutPins  = 14,
  parameter int unsigned NumInPins   = 8,
  parameter int unsigned NumSrc      = 8,
  parameter int unsigned NumSinks    = 8,
  parameter int unsigned BlankCycles = 4,
  localparam int unsigned OutSelW    = $clog2(NumSrc + 1),
  localparam int unsigned SinkSelW   = $clog2(NumInPins + 1),
  parameter logic [NumOutPins*OutSelW-1:0] OutSelRst  = '0,
  parameter logic [NumSinks*SinkSelW-1:0]  SinkSelRst = '0,
  parameter logic [NumSinks-1:0]           SinkDefault = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [PINMUX_ADDR_W-1:0] addr_i,
  input  logic [7:0]               wdata_i,
  output logic                     rvalid_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  input  logic [NumSrc-1:0]        src_o_i,
  input  logic [NumSrc-1:0]        src_oe_i,
  output logic [NumOutPins-1:0]    pin_o,
  output logic [NumOutPins-1:0]    pin_oe_o,
  input  logic [NumInPins-1:0]     pin_i,
  output logic [NumSinks-1:0]      sink_o
);

  pinmux_addr_t          w_addr;
  logic                  w_err;
  logic [31:0]           w_rdata;
  logic                  w_out_ok;
  logic                  w_sink_we;
  logic [NumOutPins-1:0] w_out_we;
  logic [NumOutPins-1:0] w_busy;
  logic [OutSelW-1:0]    w_pend_sel [NumOutPins];

  logic [SinkSelW-1:0]   r_sink_sel [NumSinks];
  logic [NumInPins-1:0]  r_sync1;
  logic [NumInPins-1:0]  r_sync2;
  logic                  r_rvalid;
  logic                  r_err;
  logic [31:0]           r_rdata;

  assign w_addr = pinmux_decode(addr_i);

  // Decode errors and read data; an erroring access never produces data.
  always_comb begin
    w_err   = 1'b0;
    w_rdata = '0;
    case (w_addr.bank)
      PINMUX_BANK_OUT: begin
        if (32'(w_addr.idx) >= NumOutPins || (we_i && 32'(wdata_i) > NumSrc)) begin
          w_err = 1'b1;
        end else if (!we_i) begin
          for (int n = 0; n < NumOutPins; n++) begin
            if (w_addr.idx == pinmux_idx_t'(n)) w_rdata = 32'(w_pend_sel[n]);
          end
        end
      end
      PINMUX_BANK_SINK: begin
        if (32'(w_addr.idx) >= NumSinks || (we_i && 32'(wdata_i) > NumInPins)) begin
          w_err = 1'b1;
        end else if (!we_i) begin
          for (int m = 0; m < NumSinks; m++) begin
            if (w_addr.idx == pinmux_idx_t'(m)) w_rdata = 32'(r_sink_sel[m]);
          end
        end
      end
      PINMUX_BANK_STATUS: begin
        if (w_addr.idx != '0 || we_i) begin
          w_err = 1'b1;
        end else begin
          w_rdata = 32'(w_busy);
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  assign w_out_ok  = req_i && we_i && !w_err && (w_addr.bank == PINMUX_BANK_OUT);
  assign w_sink_we = req_i && we_i && !w_err && (w_addr.bank == PINMUX_BANK_SINK);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= req_i;
      r_err    <= req_i && w_err;
      r_rdata  <= (req_i && !w_err && !we_i) ? w_rdata : '0;
    end
  end

  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
  assign rdata_o  = r_rdata;

  for (genvar n = 0; n < NumOutPins; n++) begin : g_out
    assign w_out_we[n] = w_out_ok && (w_addr.idx == pinmux_idx_t'(n));

    sonata_pinmux_out_slot #(
      .NumSrc      (NumSrc),
      .SelW        (OutSelW),
      .BlankCycles (BlankCycles),
      .SelRst      (OutSelRst[n*OutSelW +: OutSelW])
    ) u_slot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_en_i    (w_out_we[n]),
      .wr_sel_i   (wdata_i[OutSelW-1:0]),
      .src_o_i    (src_o_i),
      .src_oe_i   (src_oe_i),
      .pend_sel_o (w_pend_sel[n]),
      .busy_o     (w_busy[n]),
      .pin_o      (pin_o[n]),
      .pin_oe_o   (pin_oe_o[n])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int m = 0; m < NumSinks; m++) begin
        r_sink_sel[m] <= SinkSelRst[m*SinkSelW +: SinkSelW];
      end
    end else if (w_sink_we) begin
      for (int m = 0; m < NumSinks; m++) begin
        if (w_addr.idx == pinmux_idx_t'(m)) r_sink_sel[m] <= wdata_i[SinkSelW-1:0];
      end
    end
  end

  // Pads are asynchronous to clk_i; two flops before any sink sees them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pin_i;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    sink_o = SinkDefault;
    for (int m = 0; m < NumSinks; m++) begin
      for (int k = 0; k < NumInPins; k++) begin
        if (r_sink_sel[m] == SinkSelW'(k + 1)) sink_o[m] = r_sync2[k];
      end
    end
  end

endmodule

// File: tb/tb_sonata_pinmux_ctrl.sv
// tb/tb_sonata_pinmux_ctrl.sv - randomized bench for sonata_pinmux_ctrl against a cycle-stamped reference model
module tb_sonata_pinmux_ctrl;

  localparam int NOP = 14;
  localparam int NIP = 8;
  localparam int NS = 8;
  localparam int NSK = 8;
  localparam int BLANK = 4;
  localparam int HIST = 4096;
  localparam logic [NOP*4-1:0] OUT_RST = 56'h3;
  localparam logic [NSK-1:0] SINK_DEF = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  logic req, we;
  logic [9:0] addr;
  logic [7:0] wdata;
  logic rvalid, err;
  logic [31:0] rdata;
  logic [NS-1:0] src_o, src_oe;
  logic [NOP-1:0] pin_o, pin_oe;
  logic [NIP-1:0] pin_i;
  logic [NSK-1:0] sink_o;

  always #5 clk = ~clk;

  sonata_pinmux_ctrl #(
    .NumOutPins(NOP), .NumInPins(NIP), .NumSrc(NS), .NumSinks(NSK), .BlankCycles(BLANK),
    .OutSelRst(OUT_RST), .SinkSelRst('0), .SinkDefault(SINK_DEF)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .src_o_i(src_o), .src_oe_i(src_oe), .pin_o(pin_o), .pin_oe_o(pin_oe),
    .pin_i(pin_i), .sink_o(sink_o)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rand_pins = 1'b0;
  logic [NIP-1:0] pin_hist [HIST];

  // Edge counter plus a log of what each input pin looked like at every edge.
  always @(posedge clk) begin
    pin_hist[cyc % HIST] = pin_i;
    cyc = cyc + 1;
  end

  // Model: an output pin shows its pending select once cyc reaches m_ready, else nothing.
  int m_pend [NOP];
  int m_ready [NOP];
  int m_sink_sel [NSK];
  bit m_err;
  logic [31:0] m_rdata;

  function automatic void model_reset();
    for (int n = 0; n < NOP; n++) begin
      m_pend[n] = (n == 0) ? 3 : 0;
      m_ready[n] = 0;
    end
    for (int m = 0; m < NSK; m++) m_sink_sel[m] = 0;
  endfunction

  function automatic logic [NOP-1:0] exp_pin(input bit want_oe);
    logic [NOP-1:0] r = '0;
    for (int n = 0; n < NOP; n++) begin
      int a = (cyc >= m_ready[n]) ? m_pend[n] : 0;
      if (a != 0) r[n] = want_oe ? src_oe[a-1] : src_o[a-1];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_busy(input int at);
    logic [31:0] r = '0;
    for (int n = 0; n < NOP; n++) r[n] = (at < m_ready[n]);
    return r;
  endfunction

  function automatic logic [NSK-1:0] exp_sink();
    logic [NSK-1:0] r = '0;
    logic [NIP-1:0] h = pin_hist[(cyc - 2) % HIST];
    for (int m = 0; m < NSK; m++) begin
      int s = m_sink_sel[m];
      r[m] = (s == 0) ? SINK_DEF[m] : h[s-1];
    end
    return r;
  endfunction

  // Applied right after the edge that sampled the request.
  function automatic void model_access(input bit w, input logic [9:0] a, input logic [7:0] d);
    int bank = int'(a[9:8]);
    int idx = int'(a[7:0]);
    int v = int'(d);
    m_err = 1'b0;
    m_rdata = '0;
    case (bank)
      0: begin
        if (idx >= NOP || (w && v > NS)) m_err = 1'b1;
        else if (w) begin
          if (v != m_pend[idx]) begin
            m_pend[idx] = v;
            m_ready[idx] = cyc + BLANK;
          end
        end else m_rdata = 32'(m_pend[idx]);
      end
      1: begin
        if (idx >= NSK || (w && v > NIP)) m_err = 1'b1;
        else if (w) m_sink_sel[idx] = v;
        else m_rdata = 32'(m_sink_sel[idx]);
      end
      2: begin
        if (idx != 0 || w) m_err = 1'b1;
        else m_rdata = exp_busy(cyc - 1);
      end
      default: m_err = 1'b1;
    endcase
  endfunction

  function automatic logic [9:0] adr(input int bank, input int idx);
    return {2'(bank), 8'(idx)};
  endfunction

  task automatic cycle(input bit rq, input bit w, input logic [9:0] a, input logic [7:0] d);
    req = rq; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    if (rq) model_access(w, a, d);
    src_o = 8'($urandom);
    src_oe = 8'($urandom);
    if (rand_pins) pin_i = 8'($urandom);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; pin_i = '0;
    src_o = 8'($urandom); src_oe = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%0b exp=0", rvalid); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", err); end
    n_checks++; if (pin_oe !== {13'h0, src_oe[2]}) begin n_fail++; $display("FAIL reset_pin_oe got=%h exp=%h", pin_oe, {13'h0, src_oe[2]}); end
    n_checks++; if (pin_o !== {13'h0, src_o[2]}) begin n_fail++; $display("FAIL reset_pin_o got=%h exp=%h", pin_o, {13'h0, src_o[2]}); end
    rst = 1'b0;
    cycle(1'b1, 1'b0, adr(0, 0), 8'h0);
    n_checks++; if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'd3) begin n_fail++; $display("FAIL reset_read_sel0 got=%0b/%0b/%0d exp=1/0/3", rvalid, err, rdata); end
    cycle(1'b1, 1'b0, adr(2, 0), 8'h0);
    n_checks++; if (rdata !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%h/%0b exp=0/0", rdata, err); end
  endtask

  task automatic test_blank();
    cycle(1'b1, 1'b1, adr(0, 1), 8'd5);
    n_checks++; if (err !== 1'b0 || pin_oe[1] !== 1'b0) begin n_fail++; $display("FAIL blank_start got err=%0b oe1=%0b exp=0/0", err, pin_oe[1]); end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, adr(2, 0), 8'h0);
      n_checks++; if (rdata[1] !== ((i < 4) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL blank_busy i=%0d got=%0b exp=%0b", i, rdata[1], (i < 4)); end
      n_checks++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL blank_mask i=%0d got=%h exp=%h", i, rdata, m_rdata); end
      n_checks++; if (pin_oe !== exp_pin(1'b1) || pin_o !== exp_pin(1'b0)) begin n_fail++; $display("FAIL blank_pins i=%0d got=%h/%h exp=%h/%h", i, pin_oe, pin_o, exp_pin(1'b1), exp_pin(1'b0)); end
    end
    n_checks++; if (pin_oe[1] !== src_oe[4] || pin_o[1] !== src_o[4]) begin n_fail++; $display("FAIL blank_track got=%0b/%0b exp=%0b/%0b", pin_oe[1], pin_o[1], src_oe[4], src_o[4]); end
  endtask

  task automatic test_restart();
    cycle(1'b1, 1'b1, adr(0, 1), 8'd5);
    cycle(1'b1, 1'b0, adr(2, 0), 8'h0);
    cycle(1'b1, 1'b0, adr(2, 0), 8'h0);
    cycle(1'b1, 1'b1, adr(0, 1), 8'd6);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b0, adr(2, 0), 8'h0);
      n_checks++; if (rdata[1] !== ((i < 4) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL restart_busy i=%0d got=%0b exp=%0b", i, rdata[1], (i < 4)); end
      n_checks++; if (pin_oe !== exp_pin(1'b1) || pin_o !== exp_pin(1'b0)) begin n_fail++; $display("FAIL restart_pins i=%0d got=%h/%h exp=%h/%h", i, pin_oe, pin_o, exp_pin(1'b1), exp_pin(1'b0)); end
    end
    cycle(1'b1, 1'b1, adr(0, 1), 8'd6);
    cycle(1'b1, 1'b0, adr(2, 0), 8'h0);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL same_value_busy got=%h exp=0", rdata); end
    n_checks++; if (pin_oe[1] !== src_oe[5]) begin n_fail++; $display("FAIL same_value_pin got=%0b exp=%0b", pin_oe[1], src_oe[5]); end
  endtask

  task automatic test_errors();
    cycle(1'b1, 1'b1, adr(0, 2), 8'd9);
    n_checks++; if (err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL err_bad_value got=%0b/%h exp=1/0", err, rdata); end
    cycle(1'b1, 1'b0, adr(0, 2), 8'h0);
    n_checks++; if (err !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL err_unchanged got=%0b/%h exp=0/0", err, rdata); end
    cycle(1'b1, 1'b0, adr(3, 0), 8'h0);
    n_checks++; if (err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL err_bank3 got=%0b/%h exp=1/0", err, rdata); end
    cycle(1'b1, 1'b1, adr(2, 0), 8'h1);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_status_write got=%0b exp=1", err); end
    cycle(1'b1, 1'b0, adr(0, NOP), 8'h0);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_idx_range got=%0b exp=1", err); end
    cycle(1'b1, 1'b1, adr(1, 1), 8'd9);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sink_value got=%0b exp=1", err); end
    cycle(1'b1, 1'b0, adr(2, 0), 8'h0);
    n_checks++; if (err !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL err_no_blank got=%0b/%h exp=0/0", err, rdata); end
  endtask

  task automatic test_sinks();
    logic v;
    rand_pins = 1'b0;
    cycle(1'b1, 1'b1, adr(1, 2), 8'd4);
    repeat (3) cycle(1'b0, 1'b0, '0, '0);
    v = ~pin_i[3];
    pin_i[3] = v;
    cycle(1'b0, 1'b0, '0, '0);
    n_checks++; if (sink_o[2] !== ~v) begin n_fail++; $display("FAIL sink_early got=%0b exp=%0b", sink_o[2], ~v); end
    cycle(1'b0, 1'b0, '0, '0);
    n_checks++; if (sink_o[2] !== v) begin n_fail++; $display("FAIL sink_two_cycles got=%0b exp=%0b", sink_o[2], v); end
    cycle(1'b1, 1'b1, adr(1, 2), 8'd0);
    n_checks++; if (sink_o[2] !== SINK_DEF[2]) begin n_fail++; $display("FAIL sink_default got=%0b exp=%0b", sink_o[2], SINK_DEF[2]); end
    rand_pins = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) cycle(1'b1, 1'b1, adr(1, $urandom_range(0, NSK - 1)), 8'($urandom_range(0, NIP)));
      else cycle(1'b0, 1'b0, '0, '0);
      n_checks++; if (sink_o !== exp_sink()) begin n_fail++; $display("FAIL sink_rand i=%0d got=%h exp=%h", i, sink_o, exp_sink()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int op = $urandom_range(0, 5);
      bit rq = (op != 5);
      bit w = (op < 3);
      logic [9:0] a;
      logic [7:0] d;
      if (op < 2) begin a = adr(0, $urandom_range(0, NOP + 1)); d = 8'($urandom_range(0, NS + 1)); end
      else if (op == 2) begin a = adr(1, $urandom_range(0, NSK - 1)); d = 8'($urandom_range(0, NIP)); end
      else begin a = adr($urandom_range(0, 3), $urandom_range(0, 15)); d = '0; end
      cycle(rq, w, a, d);
      if (rq) begin
        n_checks++; if (rvalid !== 1'b1 || err !== m_err || rdata !== m_rdata) begin n_fail++; $display("FAIL rand_resp i=%0d got=%0b/%0b/%h exp=1/%0b/%h", i, rvalid, err, rdata, m_err, m_rdata); end
      end
      n_checks++; if (pin_oe !== exp_pin(1'b1) || pin_o !== exp_pin(1'b0)) begin n_fail++; $display("FAIL rand_pins i=%0d got=%h/%h exp=%h/%h", i, pin_oe, pin_o, exp_pin(1'b1), exp_pin(1'b0)); end
      n_checks++; if (sink_o !== exp_sink()) begin n_fail++; $display("FAIL rand_sink i=%0d got=%h exp=%h", i, sink_o, exp_sink()); end
    end
  endtask

  task automatic test_reset_mid_blank();
    cycle(1'b1, 1'b1, adr(0, 0), 8'd7);
    cycle(1'b1, 1'b1, adr(0, 0), 8'd7);
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if (pin_oe[0] !== src_oe[2] || pin_o[0] !== src_o[2]) begin n_fail++; $display("FAIL midrst_pin0 got=%0b/%0b exp=%0b/%0b", pin_oe[0], pin_o[0], src_oe[2], src_o[2]); end
    n_checks++; if (pin_oe !== exp_pin(1'b1)) begin n_fail++; $display("FAIL midrst_pins got=%h exp=%h", pin_oe, exp_pin(1'b1)); end
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid got=%0b exp=0", rvalid); end
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b1, 1'b0, adr(2, 0), 8'h0);
    n_checks++; if (rdata !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%h exp=0", rdata); end
    cycle(1'b1, 1'b0, adr(0, 0), 8'h0);
    n_checks++; if (rdata !== 32'd3) begin n_fail++; $display("FAIL midrst_sel0 got=%0d exp=3", rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_blank();
    test_restart();
    test_errors();
    test_sinks();
    test_random();
    test_reset_mid_blank();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
